rect_line_painter: RTL and testbench

//  GPU stage directly downstream of the rect copy stage. Walks the 64-entry rect buffer once per scanline.

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/rect_span_gen.sv | 42 ++++
 rtl/rect_line_painter.sv | 179 +++++++++++++++++
 tb/tb_rect_line_painter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared constants for the rect painter stage: record layout and painter state encoding.
package gpu_pkg;

    localparam int COORD_WIDTH = 13;
    localparam int RECT_COUNT  = 64;
    localparam int RECT_WORDS  = 6;

    localparam logic [2:0] OFF_FLAG  = 3'd0;
    localparam logic [2:0] OFF_X     = 3'd1;
    localparam logic [2:0] OFF_Y     = 3'd2;
    localparam logic [2:0] OFF_W     = 3'd3;
    localparam logic [2:0] OFF_H     = 3'd4;
    localparam logic [2:0] OFF_COLOR = 3'd5;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] TEST  = 3'd3;
    localparam logic [2:0] SPAN  = 3'd4;
    localparam logic [2:0] NEXT  = 3'd5;

endpackage

// File: rtl/rect_span_gen.sv
// Combinational scanline hit test and span end for one rect record.
// RECT_CLIP_EN: clip the span end to the screen edge and reject rects starting off-screen.
module rect_span_gen
    import gpu_pkg::*;
#(
    parameter int SCREEN_WIDTH = 640
) (
    input  logic [COORD_WIDTH-1:0] ty,
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic [COORD_WIDTH-1:0] w,
    input  logic [COORD_WIDTH-1:0] h,
    output logic                   hit,
    output logic [COORD_WIDTH:0]   pend
);

`ifdef RECT_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic [COORD_WIDTH:0] SW = (COORD_WIDTH + 1)'(SCREEN_WIDTH);

    logic [COORD_WIDTH:0] y_end;
    logic [COORD_WIDTH:0] x_end;

    always_comb begin
        // Sums are one bit wider so rects reaching the coordinate limit never wrap.
        y_end = {1'b0, y} + {1'b0, h};
        x_end = {1'b0, x} + {1'b0, w};
        hit   = (w != '0) && (h != '0) && (ty >= y) && ({1'b0, ty} < y_end);
        pend  = x_end;
        if (CLIP_EN) begin
            if ({1'b0, x} >= SW)
                hit = 1'b0;
            if (x_end > SW)
                pend = SW;
        end
    end

endmodule

// File: rtl/rect_line_painter.sv
// Paints one scanline per line_start from the 64-entry rect buffer into a ping-pong line buffer.
// Span clipping at the screen edge is selected by RECT_CLIP_EN (see rect_span_gen).
module rect_line_painter
    import gpu_pkg::*;
#(
    parameter int          RB_ADDR_WIDTH = 9,
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          LB_ADDR_WIDTH = 10,
    parameter logic [15:0] BG_COLOR      = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     gpu_reset,
    input  logic                     line_start,
    input  logic [COORD_WIDTH-1:0]   line_y,
    output logic [RB_ADDR_WIDTH-1:0] rb_addr,
    input  logic [15:0]              rb_data,
    output logic                     lb_we,
    output logic                     lb_sel,
    output logic [LB_ADDR_WIDTH-1:0] lb_addr,
    output logic [15:0]              lb_wdata,
    output logic                     busy,
    output logic                     overrun
);

    localparam int                       IDX_W    = $clog2(RECT_COUNT);
    localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(RECT_COUNT - 1);
    localparam logic [LB_ADDR_WIDTH-1:0] CLR_LAST = LB_ADDR_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [COORD_WIDTH:0]     SW_PX    = (COORD_WIDTH + 1)'(SCREEN_WIDTH);
    localparam logic [COORD_WIDTH:0]     PX_ONE   = (COORD_WIDTH + 1)'(1);
    localparam logic [RB_ADDR_WIDTH-1:0] RB_STEP  = RB_ADDR_WIDTH'(RECT_WORDS);

    logic [2:0]               state;
    logic [COORD_WIDTH-1:0]   ty, rx, ry, rw, rh;
    logic [15:0]              colour;
    logic [LB_ADDR_WIDTH-1:0] clr_cnt;
    logic [IDX_W-1:0]         idx;
    logic [2:0]               k;
    logic [RB_ADDR_WIDTH-1:0] rb_base;
    logic [COORD_WIDTH:0]     px, pend;
    logic                     sel, ovr;
    logic                     hit;
    logic [COORD_WIDTH:0]     span_pend;

    rect_span_gen #(
        .SCREEN_WIDTH(SCREEN_WIDTH)
    ) u_span (
        .ty  (ty),
        .x   (rx),
        .y   (ry),
        .w   (rw),
        .h   (rh),
        .hit (hit),
        .pend(span_pend)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ty      <= '0;
            rx      <= '0;
            ry      <= '0;
            rw      <= '0;
            rh      <= '0;
            colour  <= '0;
            clr_cnt <= '0;
            idx     <= '0;
            k       <= '0;
            rb_base <= '0;
            px      <= '0;
            pend    <= '0;
            sel     <= 1'b0;
            ovr     <= 1'b0;
        end else if (gpu_reset) begin
            state   <= IDLE;
            ty      <= '0;
            rx      <= '0;
            ry      <= '0;
            rw      <= '0;
            rh      <= '0;
            colour  <= '0;
            clr_cnt <= '0;
            idx     <= '0;
            k       <= '0;
            rb_base <= '0;
            px      <= '0;
            pend    <= '0;
            sel     <= 1'b0;
            ovr     <= 1'b0;
        end else if (line_start) begin
            // A new line always wins; an unfinished pass is abandoned and flagged.
            sel     <= ~sel;
            ty      <= line_y;
            if (state != IDLE)
                ovr <= 1'b1;
            state   <= CLEAR;
            clr_cnt <= '0;
            idx     <= '0;
            k       <= '0;
            rb_base <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_LAST)
                        state <= FETCH;
                    else
                        clr_cnt <= clr_cnt + 1'b1;
                end
                FETCH: begin
                    // rb_data carries the word addressed in the previous cycle.
                    if (k != 3'd0) begin
                        case (k - 3'd1)
                            OFF_X:   rx <= rb_data[COORD_WIDTH-1:0];
                            OFF_Y:   ry <= rb_data[COORD_WIDTH-1:0];
                            OFF_W:   rw <= rb_data[COORD_WIDTH-1:0];
                            OFF_H:   rh <= rb_data[COORD_WIDTH-1:0];
                            default: ;
                        endcase
                    end
                    if (k == OFF_COLOR) begin
                        k     <= 3'd0;
                        state <= TEST;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                TEST: begin
                    // The colour word lands here, overlapping the hit test.
                    colour <= rb_data;
                    if (hit) begin
                        px    <= {1'b0, rx};
                        pend  <= span_pend;
                        state <= SPAN;
                    end else begin
                        state <= NEXT;
                    end
                end
                SPAN: begin
                    px <= px + PX_ONE;
                    if (px + PX_ONE == pend)
                        state <= NEXT;
                end
                NEXT: begin
                    if (idx == IDX_LAST) begin
                        state <= IDLE;
                    end else begin
                        idx     <= idx + 1'b1;
                        rb_base <= rb_base + RB_STEP;
                        state   <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rb_addr  = '0;
        lb_we    = 1'b0;
        lb_addr  = '0;
        lb_wdata = '0;
        if (state == FETCH)
            rb_addr = rb_base + RB_ADDR_WIDTH'(k);
        if (state == CLEAR) begin
            lb_we    = 1'b1;
            lb_addr  = clr_cnt;
            lb_wdata = BG_COLOR;
        end else if (state == SPAN) begin
            lb_we    = (px < SW_PX);
            lb_addr  = px[LB_ADDR_WIDTH-1:0];
            lb_wdata = colour;
        end
    end

    assign busy    = (state != IDLE);
    assign lb_sel  = sel;
    assign overrun = ovr;

endmodule

// File: tb/tb_rect_line_painter.sv
// Directed bench for rect_line_painter with rect-buffer and line-buffer models.
module tb_rect_line_painter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        gpu_reset = 1'b0;
    logic        line_start = 1'b0;
    logic [12:0] line_y = '0;
    logic [8:0]  rb_addr;
    logic [15:0] rb_data = '0;
    logic        lb_we, lb_sel, busy, overrun;
    logic [9:0]  lb_addr;
    logic [15:0] lb_wdata;

    logic [15:0] rb_mem [0:383];
    logic [15:0] lb_mem [0:1][0:639];
    int          wr_cnt = 0;
    int          bad_addr = 0;
    int          checks = 0;
    int          fails = 0;

    rect_line_painter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .gpu_reset (gpu_reset),
        .line_start(line_start),
        .line_y    (line_y),
        .rb_addr   (rb_addr),
        .rb_data   (rb_data),
        .lb_we     (lb_we),
        .lb_sel    (lb_sel),
        .lb_addr   (lb_addr),
        .lb_wdata  (lb_wdata),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rb_data <= rb_mem[rb_addr];

    always @(posedge clk) begin
        if (lb_we) begin
            if (lb_addr < 10'd640)
                lb_mem[lb_sel][lb_addr] <= lb_wdata;
            else
                bad_addr++;
            wr_cnt++;
        end
    end

    task automatic clear_rects();
        for (int i = 0; i < 384; i++) rb_mem[i] = 16'h0000;
        for (int i = 0; i < 640; i++) begin
            lb_mem[0][i] = 16'hDEAD;
            lb_mem[1][i] = 16'hDEAD;
        end
    endtask

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h,
                            input logic [15:0] c);
        rb_mem[i*6+0] = 16'h0001;
        rb_mem[i*6+1] = 16'(x);
        rb_mem[i*6+2] = 16'(y);
        rb_mem[i*6+3] = 16'(w);
        rb_mem[i*6+4] = 16'(h);
        rb_mem[i*6+5] = c;
    endtask

    task automatic run_line(input logic [12:0] y, output int cyc);
        @(negedge clk);
        wr_cnt = 0;
        bad_addr = 0;
        line_start = 1'b1;
        line_y = y;
        @(negedge clk);
        line_start = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc >= 5000) begin
            fails++;
            $display("FAIL run_line_timeout: busy still high after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lb_we !== 1'b0 || lb_sel !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: busy=%b we=%b sel=%b ovr=%b required 0000", busy, lb_we, lb_sel, overrun);
        end
        checks++;
        if (rb_addr !== 9'd0 || lb_addr !== 10'd0 || lb_wdata !== 16'h0) begin
            fails++;
            $display("FAIL reset_buses: rb_addr=%0d lb_addr=%0d wdata=%h required 0", rb_addr, lb_addr, lb_wdata);
        end
    endtask

    task automatic test_empty();
        int cyc;
        int bad;
        clear_rects();
        run_line(13'd5, cyc);
        checks++;
        if (cyc !== 1152) begin
            fails++;
            $display("FAIL empty_busy_cycles: got %0d required 1152", cyc);
        end
        checks++;
        if (wr_cnt !== 640) begin
            fails++;
            $display("FAIL empty_writes: got %0d required 640", wr_cnt);
        end
        bad = 0;
        for (int i = 0; i < 640; i++) if (lb_mem[1][i] !== 16'h0000) bad++;
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL empty_bg: %0d pixels not BG, required 0", bad);
        end
        checks++;
        if (lb_sel !== 1'b1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL empty_sel: sel=%b ovr=%b required sel=1 ovr=0", lb_sel, overrun);
        end
    endtask

    task automatic test_overlap();
        int cyc;
        int bad;
        logic [15:0] expv [0:639];
        clear_rects();
        set_rect(0, 10, 0, 4, 8, 16'hF800);
        set_rect(1, 12, 0, 4, 8, 16'h07E0);
        for (int i = 0; i < 640; i++) expv[i] = 16'h0000;
        expv[10] = 16'hF800;
        expv[11] = 16'hF800;
        for (int i = 12; i < 16; i++) expv[i] = 16'h07E0;
        run_line(13'd3, cyc);
        bad = 0;
        for (int i = 0; i < 640; i++) begin
            if (lb_mem[lb_sel][i] !== expv[i]) begin
                if (bad < 4)
                    $display("  px%0d=%h expected %h", i, lb_mem[lb_sel][i], expv[i]);
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL overlap_pixels: %0d wrong pixels, required 0", bad);
        end
        checks++;
        if (wr_cnt !== 648 || cyc !== 1160) begin
            fails++;
            $display("FAIL overlap_counts: writes=%0d cycles=%0d required 648/1160", wr_cnt, cyc);
        end
    endtask

    task automatic test_yedge();
        int cyc;
        clear_rects();
        set_rect(0, 100, 20, 5, 1, 16'h1234);
        run_line(13'd20, cyc);
        checks++;
        if (wr_cnt !== 645 || lb_mem[lb_sel][100] !== 16'h1234 || lb_mem[lb_sel][104] !== 16'h1234
            || lb_mem[lb_sel][105] !== 16'h0000) begin
            fails++;
            $display("FAIL yedge_hit: writes=%0d px100=%h px104=%h px105=%h required 645/1234/1234/0000",
                     wr_cnt, lb_mem[lb_sel][100], lb_mem[lb_sel][104], lb_mem[lb_sel][105]);
        end
        run_line(13'd21, cyc);
        checks++;
        if (wr_cnt !== 640 || lb_mem[lb_sel][100] !== 16'h0000) begin
            fails++;
            $display("FAIL yedge_below: writes=%0d px100=%h required 640/0000", wr_cnt, lb_mem[lb_sel][100]);
        end
        run_line(13'd19, cyc);
        checks++;
        if (wr_cnt !== 640 || lb_mem[lb_sel][100] !== 16'h0000) begin
            fails++;
            $display("FAIL yedge_above: writes=%0d px100=%h required 640/0000", wr_cnt, lb_mem[lb_sel][100]);
        end
    endtask

    task automatic test_xedge();
        int cyc;
        int span_cyc;
`ifdef RECT_CLIP_EN
        span_cyc = 2;
`else
        span_cyc = 10;
`endif
        clear_rects();
        set_rect(0, 638, 0, 10, 10, 16'hABCD);
        run_line(13'd0, cyc);
        checks++;
        if (wr_cnt !== 642 || bad_addr !== 0) begin
            fails++;
            $display("FAIL xedge_writes: writes=%0d offscreen=%0d required 642/0", wr_cnt, bad_addr);
        end
        checks++;
        if (lb_mem[lb_sel][638] !== 16'hABCD || lb_mem[lb_sel][639] !== 16'hABCD
            || lb_mem[lb_sel][637] !== 16'h0000) begin
            fails++;
            $display("FAIL xedge_pixels: px637=%h px638=%h px639=%h required 0000/ABCD/ABCD",
                     lb_mem[lb_sel][637], lb_mem[lb_sel][638], lb_mem[lb_sel][639]);
        end
        checks++;
        if (cyc !== 1152 + span_cyc) begin
            fails++;
            $display("FAIL xedge_cycles: got %0d required %0d", cyc, 1152 + span_cyc);
        end
    endtask

    task automatic test_overrun();
        int n;
        int cyc;
        logic sel0;
        clear_rects();
        @(negedge clk);
        wr_cnt = 0;
        line_start = 1'b1;
        line_y = 13'd1;
        @(negedge clk);
        line_start = 1'b0;
        repeat (99) @(negedge clk);
        n = wr_cnt;
        sel0 = lb_sel;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        checks++;
        if (overrun !== 1'b1 || lb_sel !== ~sel0) begin
            fails++;
            $display("FAIL overrun_flag: ovr=%b sel=%b required ovr=1 sel=%b", overrun, lb_sel, ~sel0);
        end
        checks++;
        if (lb_we !== 1'b1 || lb_addr !== 10'd0) begin
            fails++;
            $display("FAIL overrun_restart: we=%b addr=%0d required we=1 addr=0", lb_we, lb_addr);
        end
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (wr_cnt !== n + 1 + 640 || cyc !== 1152) begin
            fails++;
            $display("FAIL overrun_writes: writes=%0d cycles=%0d required %0d/1152", wr_cnt, cyc, n + 641);
        end
        gpu_reset = 1'b1;
        @(negedge clk);
        gpu_reset = 1'b0;
        checks++;
        if (overrun !== 1'b0 || lb_sel !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL gpu_reset_clear: ovr=%b sel=%b busy=%b required 000", overrun, lb_sel, busy);
        end
    endtask

    task automatic test_async_reset();
        int t;
        clear_rects();
        set_rect(0, 0, 0, 600, 10, 16'h5A5A);
        @(negedge clk);
        line_start = 1'b1;
        line_y = 13'd2;
        @(negedge clk);
        line_start = 1'b0;
        t = 0;
        while (!(lb_we && lb_wdata == 16'h5A5A) && t < 2000) begin
            t++;
            @(negedge clk);
        end
        checks++;
        if (t >= 2000) begin
            fails++;
            $display("FAIL span_reach: no span write within %0d cycles", t);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (lb_we !== 1'b0 || busy !== 1'b0 || lb_sel !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: we=%b busy=%b sel=%b required 000", lb_we, busy, lb_sel);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        gpu_reset = 1'b1;
        line_start = 1'b1;
        @(negedge clk);
        gpu_reset = 1'b0;
        line_start = 1'b0;
        checks++;
        if (busy !== 1'b0 || lb_sel !== 1'b0 || lb_we !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority: busy=%b sel=%b we=%b required 000", busy, lb_sel, lb_we);
        end
    endtask

    initial begin
        clear_rects();
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_empty();
        test_overlap();
        test_yedge();
        test_xedge();
        test_overrun();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
